// File: rtl/pc_fetch.sv
// Instruction fetch front end: one outstanding imem request, a single-entry decode buffer and redirect handling.
// Optional misaligned-redirect trap is compiled in with `define FETCH_MISALIGN_EN.

module add32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);
  // Modular add: carry out of bit 31 is dropped, so 32'hFFFF_FFFC + 4 wraps to 0.
  assign sum = a + b;
endmodule

module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
`ifdef FETCH_MISALIGN_EN
  ,
  output logic        fault
`endif
);

`ifdef FETCH_MISALIGN_EN
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_FAULT} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;
`endif

  state_t      state, nstate;
  logic [31:0] pc, pc_inc, redir_tgt;
  logic        discard;
  logic        redir_ok;

  add32 u_pc_add (
    .a   (pc),
    .b   (32'h4),
    .sum (pc_inc)
  );

`ifdef FETCH_MISALIGN_EN
  logic bad_redir;
  // A misaligned target traps instead of being loaded; FAULT ignores all redirects.
  always_comb begin
    bad_redir = redirect && (state != S_FAULT) && (redirect_pc[1:0] != 2'b00);
    redir_ok  = redirect && (state != S_FAULT) && (redirect_pc[1:0] == 2'b00);
    redir_tgt = redirect_pc;
  end
`else
  always_comb begin
    redir_ok  = redirect;
    redir_tgt = redirect_pc & 32'hFFFF_FFFC;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      S_IDLE:  nstate = S_REQ;
      S_REQ:   if (imem_gnt) nstate = S_WAIT;
      // A redirect that meets the response drops it and refetches from the new pc.
      S_WAIT:  if (imem_rvalid) nstate = (discard || redirect) ? S_REQ : S_HOLD;
      S_HOLD:  if (out_ready || redirect) nstate = S_REQ;
`ifdef FETCH_MISALIGN_EN
      S_FAULT: nstate = S_FAULT;
`endif
      default: nstate = S_IDLE;
    endcase
`ifdef FETCH_MISALIGN_EN
    if (bad_redir) nstate = S_FAULT;
`endif
  end

  always_comb begin
    imem_req  = (state == S_REQ);
    imem_addr = pc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      discard   <= 1'b0;
      out_valid <= 1'b0;
      out_instr <= 32'h0;
      out_pc    <= 32'h0;
`ifdef FETCH_MISALIGN_EN
      fault     <= 1'b0;
`endif
    end else begin
      if (redir_ok) begin
        pc        <= redir_tgt;
        out_valid <= 1'b0;
        // The request already in flight must have its response thrown away.
        discard   <= ((state == S_REQ) && imem_gnt) || ((state == S_WAIT) && !imem_rvalid);
      end else begin
        case (state)
          S_WAIT: if (imem_rvalid) begin
            discard <= 1'b0;
            if (!discard) begin
              out_instr <= imem_rdata;
              out_pc    <= pc;
              pc        <= pc_inc;
              out_valid <= 1'b1;
            end
          end
          S_HOLD: if (out_ready) out_valid <= 1'b0;
          default: ;
        endcase
      end
`ifdef FETCH_MISALIGN_EN
      if (bad_redir) begin
        fault     <= 1'b1;
        out_valid <= 1'b0;
      end
`endif
    end
  end

endmodule
